// File: rtl/dht11_scheduler.sv
// -----------------------------------------------------------------------------
// dht11_scheduler
//
// Purpose:
//   Shares a single DHT11 controller between two external requesters (A, B)
//   and an internal auto-poll. It enforces the sensor minimum start-to-start
//   interval, times out hung transactions, retries failed measurements and
//   latches the last good reading. Every requester whose request was folded
//   into a measurement is acked when that measurement finishes.
//
// Optional feature:
//   Define DHT11_STATS_EN to build the saturating ok/fail statistics counters.
//   When it is undefined, stat_ok and stat_fail are tied to zero.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_a, req_b        1-cycle measurement request pulses
//   auto_en             enable the periodic internal request
//   ack_a, ack_b        1-cycle completion pulse per served requester
//   dht_start           1-cycle start pulse to the DHT11 controller
//   dht_done            controller done level (rising edge ends a transaction)
//   dht_valid           controller checksum ok, sampled on dht_done rising edge
//   dht_hum, dht_tmp    controller humidity / temperature
//   rd_hum, rd_tmp      last valid reading
//   rd_valid            at least one valid reading latched since reset
//   rd_update           1-cycle pulse when rd_hum/rd_tmp are reloaded
//   err                 1-cycle pulse when all retries are exhausted
//   busy                high while a measurement is in flight
//   stat_ok, stat_fail  measurement statistics
// -----------------------------------------------------------------------------
module dht11_scheduler #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int MIN_INTERVAL_MS = 2000,
  parameter int TIMEOUT_MS      = 30,
  parameter int MAX_RETRY       = 2,
  parameter int AUTO_PERIOD_MS  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        auto_en,
  output logic        ack_a,
  output logic        ack_b,
  output logic        dht_start,
  input  logic        dht_done,
  input  logic        dht_valid,
  input  logic [15:0] dht_hum,
  input  logic [15:0] dht_tmp,
  output logic [15:0] rd_hum,
  output logic [15:0] rd_tmp,
  output logic        rd_valid,
  output logic        rd_update,
  output logic        err,
  output logic        busy,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_fail
);

  localparam int TICK_DIV  = (CLK_HZ >= 1000) ? (CLK_HZ / 1000) : 1;
  localparam int SINCE_MAX = (MIN_INTERVAL_MS > AUTO_PERIOD_MS) ? MIN_INTERVAL_MS : AUTO_PERIOD_MS;
  localparam int PW        = $clog2(TICK_DIV + 1);
  localparam int SW        = $clog2(SINCE_MAX + 2);
  localparam int TW        = $clog2(TIMEOUT_MS + 2);
  localparam int RW        = $clog2(MAX_RETRY + 2);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SINCE_SAT = SW'(SINCE_MAX);
  localparam logic [SW-1:0] MIN_IV    = SW'(MIN_INTERVAL_MS);
  localparam logic [SW-1:0] AUTO_IV   = SW'(AUTO_PERIOD_MS);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_MS);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_EVAL  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_since;
  logic          r_partial;
  logic [TW-1:0] r_to;
  logic          r_done_d;
  logic [2:0]    r_pend;
  logic [2:0]    r_served;
  logic [RW-1:0] r_retry;
  logic          r_ok;

  logic          r_ack_a;
  logic          r_ack_b;
  logic          r_dht_start;
  logic [15:0]   r_rd_hum;
  logic [15:0]   r_rd_tmp;
  logic          r_rd_valid;
  logic          r_rd_update;
  logic          r_err;
  logic          r_busy;

  logic          w_tick;
  logic          w_rise;
  logic          w_timeout;
  logic          w_go;
  logic          w_auto_set;
  logic [2:0]    w_pend_set;
  logic          w_start;
  logic          w_wait;
  logic          w_eval_ok;
  logic          w_eval_fail;
  logic          w_retry;
  logic          w_give_up;
  logic          w_finish;

  assign w_tick     = (r_presc == TICK_LAST);
  assign w_rise     = dht_done & ~r_done_d;
  assign w_timeout  = (r_to == TO_LIM);
  // since_ms is still stale in START (it is cleared on that edge), so the
  // auto-poll must not re-arm there.
  assign w_auto_set = auto_en && (r_since >= AUTO_IV) && (r_state != S_START);
  assign w_pend_set = {w_auto_set, req_b, req_a};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_START; else w_state_nxt = S_IDLE;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_rise || w_timeout) w_state_nxt = S_EVAL; else w_state_nxt = S_WAIT;
      S_EVAL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_go        = ((r_pend != 3'b000) || (r_served != 3'b000)) && (r_since >= MIN_IV);
    w_start     = (r_state == S_START);
    w_wait      = (r_state == S_WAIT);
    w_eval_ok   = (r_state == S_EVAL) && r_ok;
    w_eval_fail = (r_state == S_EVAL) && !r_ok;
    w_retry     = w_eval_fail && (r_retry < RETRY_LIM);
    w_give_up   = w_eval_fail && !(r_retry < RETRY_LIM);
    w_finish    = w_eval_ok || w_give_up;
  end

  // Free-running 1 ms prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Milliseconds since the last start. The tick that closes the partial
  // millisecond in which START happened is not counted, so the holdoff
  // always spans at least MIN_INTERVAL_MS full milliseconds of clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_since   <= '0;
      r_partial <= 1'b0;
    end else if (w_start) begin
      r_since   <= '0;
      r_partial <= 1'b1;
    end else if (w_tick) begin
      r_partial <= 1'b0;
      if (!r_partial && (r_since != SINCE_SAT)) r_since <= r_since + SW'(1);
      else                                      r_since <= r_since;
    end else begin
      r_since   <= r_since;
      r_partial <= r_partial;
    end
  end

  // Transaction timeout counter, running only while waiting for done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_to <= '0;
    else if (w_start)                              r_to <= '0;
    else if (w_wait && w_tick && (r_to != TO_LIM)) r_to <= r_to + TW'(1);
    else                                           r_to <= r_to;
  end

  // Request bookkeeping: pending requests, served set, retry count, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_d <= 1'b0;
      r_pend   <= 3'b000;
      r_served <= 3'b000;
      r_retry  <= '0;
      r_ok     <= 1'b0;
    end else begin
      r_done_d <= dht_done;
      // a new request in the clearing cycle survives
      r_pend   <= (w_start ? 3'b000 : r_pend) | w_pend_set;
      if (w_start)       r_served <= r_served | r_pend;
      else if (w_finish) r_served <= 3'b000;
      else               r_served <= r_served;
      if (w_finish)     r_retry <= '0;
      else if (w_retry) r_retry <= r_retry + RW'(1);
      else              r_retry <= r_retry;
      // an edge beats a simultaneous timeout
      if (w_wait && (w_rise || w_timeout)) r_ok <= w_rise & dht_valid;
      else                                 r_ok <= r_ok;
    end
  end

  // Registered outputs; start/busy are aligned with the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dht_start <= 1'b0;
      r_busy      <= 1'b0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_err       <= 1'b0;
      r_rd_update <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_hum    <= 16'h0000;
      r_rd_tmp    <= 16'h0000;
    end else begin
      r_dht_start <= (w_state_nxt == S_START);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_ack_a     <= w_finish && r_served[0];
      r_ack_b     <= w_finish && r_served[1];
      r_err       <= w_give_up;
      r_rd_update <= w_eval_ok;
      if (w_eval_ok) begin
        r_rd_hum   <= dht_hum;
        r_rd_tmp   <= dht_tmp;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_hum   <= r_rd_hum;
        r_rd_tmp   <= r_rd_tmp;
        r_rd_valid <= r_rd_valid;
      end
    end
  end

  assign dht_start = r_dht_start;
  assign busy      = r_busy;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign err       = r_err;
  assign rd_update = r_rd_update;
  assign rd_valid  = r_rd_valid;
  assign rd_hum    = r_rd_hum;
  assign rd_tmp    = r_rd_tmp;

`ifdef DHT11_STATS_EN
  logic [15:0] r_stat_ok;
  logic [15:0] r_stat_fail;

  // Saturating measurement statistics; retried attempts count as failures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ok   <= 16'h0000;
      r_stat_fail <= 16'h0000;
    end else begin
      if (w_eval_ok && (r_stat_ok != 16'hFFFF)) r_stat_ok <= r_stat_ok + 16'h0001;
      else                                      r_stat_ok <= r_stat_ok;
      if (w_eval_fail && (r_stat_fail != 16'hFFFF)) r_stat_fail <= r_stat_fail + 16'h0001;
      else                                          r_stat_fail <= r_stat_fail;
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_fail = r_stat_fail;
`else
  assign stat_ok   = 16'h0000;
  assign stat_fail = 16'h0000;
`endif

endmodule

// File: tb/tb_dht11_scheduler.sv
// Self-checking bench for dht11_scheduler at CLK_HZ=10_000 (1 ms = 10 clk).
module tb_dht11_scheduler;

  localparam int P_CLK_HZ = 10_000;
  localparam int P_MIN_MS = 20;
  localparam int P_TO_MS  = 5;
  localparam int P_MAXR   = 2;
  localparam int P_AUTO   = 50;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_a     = 1'b0;
  logic        req_b     = 1'b0;
  logic        auto_en   = 1'b0;
  logic        dht_done  = 1'b0;
  logic        dht_valid = 1'b0;
  logic [15:0] dht_hum   = 16'h0000;
  logic [15:0] dht_tmp   = 16'h0000;
  logic        ack_a, ack_b, dht_start, rd_valid, rd_update, err, busy;
  logic [15:0] rd_hum, rd_tmp, stat_ok, stat_fail;

  always #5 clk = ~clk;

  dht11_scheduler #(
    .CLK_HZ(P_CLK_HZ), .MIN_INTERVAL_MS(P_MIN_MS), .TIMEOUT_MS(P_TO_MS),
    .MAX_RETRY(P_MAXR), .AUTO_PERIOD_MS(P_AUTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .auto_en(auto_en),
    .ack_a(ack_a), .ack_b(ack_b), .dht_start(dht_start), .dht_done(dht_done),
    .dht_valid(dht_valid), .dht_hum(dht_hum), .dht_tmp(dht_tmp),
    .rd_hum(rd_hum), .rd_tmp(rd_tmp), .rd_valid(rd_valid), .rd_update(rd_update),
    .err(err), .busy(busy), .stat_ok(stat_ok), .stat_fail(stat_fail)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor: counts output pulses, sampled on the falling edge
  int cyc = 0, n_start = 0, last_start = 0;
  int n_ack_a = 0, n_ack_b = 0, n_ab = 0, n_err = 0, n_err_a = 0, n_upd = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dht_start) begin
      n_start    <= n_start + 1;
      last_start <= cyc + 1;
    end
    if (ack_a)          n_ack_a <= n_ack_a + 1;
    if (ack_b)          n_ack_b <= n_ack_b + 1;
    if (ack_a && ack_b) n_ab    <= n_ab + 1;
    if (err)            n_err   <= n_err + 1;
    if (err && ack_a)   n_err_a <= n_err_a + 1;
    if (rd_update)      n_upd   <= n_upd + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    n_tests++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int s0, input int lim);
    int k;
    k = 0;
    while (n_start == s0 && k < lim) begin
      step(1);
      k++;
    end
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      step(1);
      k++;
    end
  endtask

  task automatic respond(input logic v, input logic [15:0] h, input logic [15:0] t);
    dht_valid = v;
    dht_hum   = h;
    dht_tmp   = t;
    dht_done  = 1'b1;
    step(3);
    dht_done  = 1'b0;
  endtask

  typedef struct packed {
    logic        ra;
    logic        rb;
    logic        rb_mid;   // pulse req_b while the measurement is in flight
    logic        resp;     // 1: controller answers, 0: let it time out
    logic        valid;
    logic [15:0] hum;
    logic [15:0] tmp;
    logic        e_a;
    logic        e_b;
    logic        e_err;
    logic        e_upd;
    logic [15:0] e_hum;
    logic [15:0] e_tmp;
  } vec_t;

  vec_t vecs [0:9];

  int ref_cyc, gap;
  int s_st, s_a, s_b, s_ab, s_err, s_ea, s_upd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               ra    rb    mid   resp  valid hum       tmp       a     b     err   upd   e_hum     e_tmp
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3700, 16'h1A00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3700, 16'h1A00};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3800, 16'h1B00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3800, 16'h1B00};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3900, 16'h1C00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3900, 16'h1C00};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 16'h1D00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h1D00};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h1D00};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h1D00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h1D00};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h1D00};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h1D00};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4100, 16'h1E00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4100, 16'h1E00};

    // Reset state
    step(3);
    chk("rst_start", dht_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", {ack_a, ack_b, err, rd_update}, 4'h0);
    chk("rst_rd", {rd_valid, rd_hum, rd_tmp}, 33'h0);
    chk("rst_stats", {stat_ok, stat_fail}, 32'h0);
    rst_n   = 1'b1;
    ref_cyc = cyc;
    step(4);

    // Table-driven measurements (T1..T4)
    for (int i = 0; i < 10; i++) begin
      s_st = n_start; s_a = n_ack_a; s_b = n_ack_b; s_ab = n_ab;
      s_err = n_err; s_ea = n_err_a; s_upd = n_upd;
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      step(1);
      req_a = 1'b0;
      req_b = 1'b0;
      wait_start(s_st, 1000);
      gap     = last_start - ref_cyc;
      ref_cyc = last_start;
      chk_rng($sformatf("v%0d_start_gap", i), gap, 200, 220);
      if (vecs[i].rb_mid) begin
        step(5);
        req_b = 1'b1;
        step(1);
        req_b = 1'b0;
      end
      if (vecs[i].resp) begin
        step(15);
        respond(vecs[i].valid, vecs[i].hum, vecs[i].tmp);
      end
      wait_idle(300);
      step(3);
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
      chk($sformatf("v%0d_starts", i), n_start - s_st, 1);
      chk($sformatf("v%0d_ack_a", i), n_ack_a - s_a, vecs[i].e_a);
      chk($sformatf("v%0d_ack_b", i), n_ack_b - s_b, vecs[i].e_b);
      chk($sformatf("v%0d_ack_ab_same", i), n_ab - s_ab, vecs[i].e_a & vecs[i].e_b);
      chk($sformatf("v%0d_err", i), n_err - s_err, vecs[i].e_err);
      chk($sformatf("v%0d_err_with_ack", i), n_err_a - s_ea, vecs[i].e_err & vecs[i].e_a);
      chk($sformatf("v%0d_rd_update", i), n_upd - s_upd, vecs[i].e_upd);
      chk($sformatf("v%0d_rd_hum", i), rd_hum, vecs[i].e_hum);
      chk($sformatf("v%0d_rd_tmp", i), rd_tmp, vecs[i].e_tmp);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, 1'b1);
    end

`ifdef DHT11_STATS_EN
    chk("stat_ok", stat_ok, 16'd5);
    chk("stat_fail", stat_fail, 16'd5);
`else
    chk("stat_ok", stat_ok, 16'd0);
    chk("stat_fail", stat_fail, 16'd0);
`endif

    // T5: auto-poll only, no acks
    s_a = n_ack_a; s_b = n_ack_b;
    auto_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s_st = n_start; s_upd = n_upd;
      wait_start(s_st, 800);
      gap     = last_start - ref_cyc;
      ref_cyc = last_start;
      chk_rng($sformatf("auto%0d_gap", j), gap, 500, 520);
      step(15);
      respond(1'b1, 16'h5000 + 16'(j), 16'h2000 + 16'(j));
      wait_idle(300);
      step(3);
      chk($sformatf("auto%0d_update", j), n_upd - s_upd, 1);
      chk($sformatf("auto%0d_rd_hum", j), rd_hum, 16'h5000 + 16'(j));
    end
    auto_en = 1'b0;
    chk("auto_no_ack", (n_ack_a - s_a) + (n_ack_b - s_b), 0);

    // T6: reset in the middle of a transaction
    s_st = n_start;
    req_a = 1'b1;
    step(1);
    req_a = 1'b0;
    wait_start(s_st, 1000);
    step(10);
    chk("t6_busy_pre", busy, 1'b1);
    s_a = n_ack_a; s_err = n_err;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rd", {rd_valid, rd_hum, rd_tmp}, 33'h0);
    step(3);
    rst_n   = 1'b1;
    ref_cyc = cyc;
    step(2);
    chk("t6_no_ack_err", (n_ack_a - s_a) + (n_err - s_err), 0);
    s_st = n_start; s_a = n_ack_a;
    req_a = 1'b1;
    step(1);
    req_a = 1'b0;
    wait_start(s_st, 1000);
    chk_rng("t6_first_start", last_start - ref_cyc, 200, 220);
    step(15);
    respond(1'b1, 16'h3300, 16'h1500);
    wait_idle(300);
    step(3);
    chk("t6_ack_a", n_ack_a - s_a, 1);
    chk("t6_rd", {rd_valid, rd_hum, rd_tmp}, {1'b1, 16'h3300, 16'h1500});
`ifdef DHT11_STATS_EN
    chk("t6_stat_ok", stat_ok, 16'd1);
`else
    chk("t6_stat_ok", stat_ok, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
